// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state type, requester ids and default widths for ram_arbiter
package ram_arb_pkg;
    typedef enum logic [1:0] {ARB, LOCK_A, LOCK_B} state_t;
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;
    localparam int DEF_AW = 5;
    localparam int DEF_DW = 32;
endpackage

// File: rtl/ram_arbiter_rr_grant2.sv
// rr_grant2: two-way grant, round-robin by default, A-first when RAM_ARB_FIXED_PRIO_EN is defined
module rr_grant2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_arb,
    output logic [1:0] o_gnt
);
`ifdef RAM_ARB_FIXED_PRIO_EN
    assign o_gnt = {i_req[REQ_B] & ~i_req[REQ_A], i_req[REQ_A]};
`else
    logic r_prio;
    logic w_pick_b;
    assign w_pick_b = i_req[REQ_B] & (~i_req[REQ_A] | r_prio);
    assign o_gnt    = {w_pick_b, i_req[REQ_A] & ~w_pick_b};
    // prio points at the side that lost; it only moves on grants made with no owner
    always_ff @(posedge clk) begin
        if (rst) r_prio <= REQ_A;
        else if (i_arb && |i_req) r_prio <= ~w_pick_b;
    end
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two requesters sharing one single-port sync RAM with burst lock
// Build with RAM_ARB_FIXED_PRIO_EN to make A always win arbitration.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic          a_wen,
    input  logic          a_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ready,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_valid,
    input  logic          b_wen,
    input  logic          b_lock,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ready,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          ram_cen,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [1:0]    w_req, w_gnt;
    logic          w_sel_b, w_lock;
    logic          r_rva, r_rvb;
    logic [DW-1:0] r_rda, r_rdb;
    // a locked owner masks the other side out before arbitration
    assign w_req = rst ? 2'b00 :
                   r_state == LOCK_A ? {1'b0, a_valid} :
                   r_state == LOCK_B ? {b_valid, 1'b0} : {b_valid, a_valid};
    rr_grant2 u_grant (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req),
        .i_arb (r_state == ARB),
        .o_gnt (w_gnt)
    );
    assign a_ready  = w_gnt[REQ_A];
    assign b_ready  = w_gnt[REQ_B];
    assign w_sel_b  = w_gnt[REQ_B];
    assign w_lock   = w_sel_b ? b_lock : a_lock;
    assign ram_cen  = |w_gnt;
    assign ram_wen  = ram_cen & (w_sel_b ? b_wen : a_wen);
    assign ram_addr = ram_cen ? (w_sel_b ? b_addr : a_addr) : '0;
    assign ram_din  = ram_cen ? (w_sel_b ? b_wdata : a_wdata) : '0;
    // r_cnt counts grants already given inside the current lock, including the entry grant
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        if (r_state == ARB) begin
            if (ram_cen && w_lock && LOCK_MAX > 1) begin
                w_next     = w_sel_b ? LOCK_B : LOCK_A;
                w_cnt_next = CW'(1);
            end
        end else if (ram_cen && w_lock && r_cnt != CW'(LOCK_MAX - 1)) begin
            w_cnt_next = r_cnt + CW'(1);
        end else begin
            w_next     = ARB;
            w_cnt_next = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB;
            r_cnt   <= '0;
            r_rva   <= 1'b0;
            r_rvb   <= 1'b0;
            r_rda   <= '0;
            r_rdb   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_rva   <= a_ready & ~a_wen;
            r_rvb   <= b_ready & ~b_wen;
            if (r_rva) r_rda <= ram_dout;
            if (r_rvb) r_rdb <= ram_dout;
        end
    end
    assign a_rvalid = r_rva;
    assign b_rvalid = r_rvb;
    assign a_rdata  = r_rva ? ram_dout : r_rda;
    assign b_rdata  = r_rvb ? ram_dout : r_rdb;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed plus random checks of ram_arbiter against a behavioural model
module tb_ram_arbiter;
    localparam int LOCK_MAX = 8;
`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_wen, a_lock, b_valid, b_wen, b_lock;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_ready, a_rvalid, b_ready, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        ram_cen, ram_wen;
    logic [4:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = '0;
    logic [31:0] mem [32] = '{default: '0};

    int          n_checks = 0;
    int          n_fail = 0;
    int          m_prio = 0;
    int          m_owner = -1;
    int          m_run = 0;
    bit          m_rv [2] = '{1'b0, 1'b0};
    logic [31:0] m_rd [2] = '{32'h0, 32'h0};
    logic [31:0] ref_mem [32] = '{default: '0};
    int          last_g = -1;
    logic [1:0]  obs_gnt;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ram_cen) begin
            if (ram_wen) mem[ram_addr] <= ram_din;
            else ram_dout <= mem[ram_addr];
        end

    ram_arbiter #(.AW(5), .DW(32), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_wen(a_wen), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_wen(b_wen), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv_a(input bit v, input bit w, input bit l, input logic [4:0] ad, input logic [31:0] d);
        a_valid = v; a_wen = w; a_lock = l; a_addr = ad; a_wdata = d;
    endtask

    task automatic drv_b(input bit v, input bit w, input bit l, input logic [4:0] ad, input logic [31:0] d);
        b_valid = v; b_wen = w; b_lock = l; b_addr = ad; b_wdata = d;
    endtask

    // who should win this cycle, from the ownership and priority rules
    function automatic int exp_grant();
        if (rst) return -1;
        if (m_owner == 0) return a_valid ? 0 : -1;
        if (m_owner == 1) return b_valid ? 1 : -1;
        if (a_valid && b_valid) return FIXED ? 0 : m_prio;
        if (a_valid) return 0;
        if (b_valid) return 1;
        return -1;
    endfunction

    task automatic tick();
        int          g;
        bit          we, lk;
        logic [4:0]  ad;
        logic [31:0] wd;
        @(negedge clk);
        g  = exp_grant();
        we = (g == 1) ? b_wen : a_wen;
        lk = (g == 1) ? b_lock : a_lock;
        ad = (g == 1) ? b_addr : a_addr;
        wd = (g == 1) ? b_wdata : a_wdata;
        obs_gnt = {b_ready, a_ready};
        chk("a_ready", 32'(a_ready), 32'(g == 0));
        chk("b_ready", 32'(b_ready), 32'(g == 1));
        chk("ram_cen", 32'(ram_cen), 32'(g >= 0));
        chk("ram_wen", 32'(ram_wen), 32'(g >= 0 && we));
        chk("ram_addr", 32'(ram_addr), (g >= 0) ? 32'(ad) : 32'h0);
        chk("ram_din", ram_din, (g >= 0) ? wd : 32'h0);
        chk("a_rvalid", 32'(a_rvalid), 32'(m_rv[0]));
        chk("b_rvalid", 32'(b_rvalid), 32'(m_rv[1]));
        chk("a_rdata", a_rdata, m_rd[0]);
        chk("b_rdata", b_rdata, m_rd[1]);
        @(posedge clk);
        #1;
        if (rst) begin
            m_owner = -1; m_prio = 0; m_run = 0;
            m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
        end else begin
            m_rv[0] = 1'b0; m_rv[1] = 1'b0;
            if (g >= 0) begin
                if (we) ref_mem[ad] = wd;
                else begin m_rv[g] = 1'b1; m_rd[g] = ref_mem[ad]; end
            end
            if (m_owner >= 0) begin
                if (g < 0) m_owner = -1;
                else begin
                    m_run++;
                    if (!lk || m_run >= LOCK_MAX) m_owner = -1;
                end
            end else if (g >= 0) begin
                if (!FIXED) m_prio = 1 - g;
                if (lk && LOCK_MAX > 1) begin m_owner = g; m_run = 1; end
            end
        end
        last_g = g;
    endtask

    initial begin
        rst = 1'b1;
        drv_a(1, 0, 0, 5'd3, 32'h0);
        drv_b(1, 0, 0, 5'd4, 32'h0);
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        // round-robin right after reset: A first, then alternating
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_gnt", 32'(obs_gnt), FIXED ? 32'd1 : ((i % 2 == 0) ? 32'd1 : 32'd2));
        end
        drv_b(0, 0, 0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            drv_a(1, 1, 0, 5'(i), $urandom);
            tick();
        end
        drv_a(1, 1, 0, 5'd31, 32'hDEADBEEF);
        tick();
        drv_a(1, 0, 0, 5'd31, 32'h0);
        tick();
        chk("wr_rd_valid", 32'(a_rvalid), 32'd1);
        chk("wr_rd_data", a_rdata, 32'hDEADBEEF);
        drv_a(0, 0, 0, 5'd0, 32'h0);
        tick();
        // lock cap: A locked alone first, B waits from the second cycle
        drv_a(1, 0, 1, 5'd7, 32'h0);
        for (int i = 0; i < 9; i++) begin
            if (i == 1) drv_b(1, 0, 0, 5'd9, 32'h0);
            tick();
            chk("cap_gnt", 32'(obs_gnt), (i < 8 || FIXED) ? 32'd1 : 32'd2);
        end
        drv_a(0, 0, 0, 5'd0, 32'h0);
        drv_b(0, 0, 0, 5'd0, 32'h0);
        tick();
        // lock release: A drops lock on its third grant, B then wins
        drv_b(1, 0, 0, 5'd12, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drv_a(1, 0, i < 2, 5'(20 + i), 32'h0);
            else drv_a(0, 0, 0, 5'd0, 32'h0);
            tick();
            chk("rel_gnt", 32'(obs_gnt), (i < 3) ? 32'd1 : 32'd2);
        end
        // owner goes idle inside its lock: nobody is granted that cycle
        drv_b(0, 0, 0, 5'd0, 32'h0);
        drv_a(1, 0, 1, 5'd1, 32'h0);
        tick();
        chk("idle_lock0", 32'(obs_gnt), 32'd1);
        drv_a(0, 0, 0, 5'd0, 32'h0);
        drv_b(1, 1, 0, 5'd2, 32'h12345678);
        tick();
        chk("idle_lock1", 32'(obs_gnt), 32'd0);
        tick();
        chk("idle_lock2", 32'(obs_gnt), 32'd2);
        drv_b(0, 0, 0, 5'd0, 32'h0);
        tick();
        // random traffic; a request stays stable until it is accepted
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!a_valid || last_g == 0)
                drv_a($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0, 5'($urandom), $urandom);
            if (!b_valid || last_g == 1)
                drv_b($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0, 5'($urandom), $urandom);
            tick();
        end
        rst = 1'b0;
        drv_a(0, 0, 0, 5'd0, 32'h0);
        drv_b(0, 0, 0, 5'd0, 32'h0);
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
